// File: rtl/wishbone_cmd_master_if.sv
// Bundle of command, response and WISHBONE signals for wishbone_cmd_master.
// Signal suffixes (_i/_o) are from the master's point of view.
interface wishbone_cmd_master_if;
  // host command channel
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_wr_i;
  logic [15:0] cmd_adr_i;
  logic [7:0]  cmd_dat_i;
  logic [3:0]  cmd_len_i;

  // host response channel
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [7:0]  rsp_dat_o;
  logic [1:0]  rsp_status_o;
  logic        rsp_last_o;

  // WISHBONE classic bus
  logic        cyc_o;
  logic        stb_o;
  logic        wr_o;
  logic [15:0] adr_o;
  logic [7:0]  dat_o;
  logic [7:0]  dat_i;
  logic        ack_i;
  logic        err_i;
  logic        rty_i;

  modport master (
    input  cmd_valid_i, cmd_wr_i, cmd_adr_i, cmd_dat_i, cmd_len_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_dat_o, rsp_status_o, rsp_last_o,
    input  rsp_ready_i,
    output cyc_o, stb_o, wr_o, adr_o, dat_o,
    input  dat_i, ack_i, err_i, rty_i
  );

  modport slave (
    output cmd_valid_i, cmd_wr_i, cmd_adr_i, cmd_dat_i, cmd_len_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_dat_o, rsp_status_o, rsp_last_o,
    output rsp_ready_i,
    input  cyc_o, stb_o, wr_o, adr_o, dat_o,
    output dat_i, ack_i, err_i, rty_i
  );
endinterface

// File: rtl/wishbone_cmd_master.sv
// Single-master WISHBONE initiator: host byte commands become classic cycles
// with retry, error and timeout handling; one response is returned per beat.
module wishbone_cmd_master #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRY      = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  wishbone_cmd_master_if.master bus
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ERR     = 2'b01;
  localparam logic [1:0] ST_RETRY   = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STROBE,
    S_BACKOFF,
    S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic          wr_q, wr_d;
  logic [15:0]   adr_q, adr_d;
  logic [7:0]    wdat_q, wdat_d;
  logic [4:0]    beats_q, beats_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_last_q, rsp_last_d;
  logic [7:0]    rsp_dat_q, rsp_dat_d;
  logic [1:0]    rsp_status_q, rsp_status_d;

  // Beat failure: set in STROBE, finished by a shared abort path below.
  logic          fail;
  logic [1:0]    fail_status;

  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    adr_d        = adr_q;
    wdat_d       = wdat_q;
    beats_d      = beats_q;
    retry_d      = retry_q;
    timer_d      = timer_q;
    cyc_d        = cyc_q;
    stb_d        = stb_q;
    cmd_ready_d  = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    rsp_last_d   = rsp_last_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_status_d = rsp_status_q;
    fail         = 1'b0;
    fail_status  = ST_OK;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid_i && cmd_ready_q) begin
          wr_d    = bus.cmd_wr_i;
          adr_d   = bus.cmd_adr_i;
          wdat_d  = bus.cmd_dat_i;
          beats_d = bus.cmd_wr_i ? 5'd1 : ({1'b0, bus.cmd_len_i} + 5'd1);
          retry_d = '0;
          timer_d = '0;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          state_d = S_STROBE;
        end else begin
          cmd_ready_d = 1'b1;
        end
      end

      S_STROBE: begin
        if (bus.err_i) begin
          fail        = 1'b1;
          fail_status = ST_ERR;
        end else if (bus.rty_i) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RW'(1);
            timer_d = '0;
            stb_d   = 1'b0;
            state_d = S_BACKOFF;
          end else begin
            fail        = 1'b1;
            fail_status = ST_RETRY;
          end
        end else if (bus.ack_i) begin
          rsp_dat_d    = wr_q ? 8'h00 : bus.dat_i;
          rsp_status_d = ST_OK;
          rsp_last_d   = (beats_q == 5'd1);
          rsp_valid_d  = 1'b1;
          // Keep the cycle open only while more beats follow.
          cyc_d        = (beats_q != 5'd1);
          stb_d        = 1'b0;
          state_d      = S_RESP;
        end else if (timer_q == TIMER_LAST) begin
          fail        = 1'b1;
          fail_status = ST_TIMEOUT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_BACKOFF: begin
        stb_d   = 1'b1;
        state_d = S_STROBE;
      end

      S_RESP: begin
        if (bus.rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          rsp_last_d  = 1'b0;
          if (rsp_last_q) begin
            cyc_d       = 1'b0;
            cmd_ready_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            adr_d   = adr_q + 16'd1;
            retry_d = '0;
            timer_d = '0;
            beats_d = beats_q - 5'd1;
            stb_d   = 1'b1;
            state_d = S_STROBE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
      end
    endcase

    // A failed beat aborts the rest of the command and closes the cycle.
    if (fail) begin
      rsp_dat_d    = 8'h00;
      rsp_status_d = fail_status;
      rsp_last_d   = 1'b1;
      rsp_valid_d  = 1'b1;
      cyc_d        = 1'b0;
      stb_d        = 1'b0;
      state_d      = S_RESP;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      wr_q         <= 1'b0;
      adr_q        <= '0;
      wdat_q       <= '0;
      beats_q      <= '0;
      retry_q      <= '0;
      timer_q      <= '0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_last_q   <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      adr_q        <= adr_d;
      wdat_q       <= wdat_d;
      beats_q      <= beats_d;
      retry_q      <= retry_d;
      timer_q      <= timer_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_last_q   <= rsp_last_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  assign bus.cmd_ready_o  = cmd_ready_q;
  assign bus.rsp_valid_o  = rsp_valid_q;
  assign bus.rsp_dat_o    = rsp_dat_q;
  assign bus.rsp_status_o = rsp_status_q;
  assign bus.rsp_last_o   = rsp_last_q;
  assign bus.cyc_o        = cyc_q;
  assign bus.stb_o        = stb_q;
  assign bus.wr_o         = wr_q;
  assign bus.adr_o        = adr_q;
  assign bus.dat_o        = wdat_q;

endmodule
